// File: rtl/pc_pkg.sv
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types and state encodings for the program counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    // Fetch FSM encodings
    localparam logic [1:0] c_RUN     = 2'd0;
    localparam logic [1:0] c_WAIT_LO = 2'd1;
    localparam logic [1:0] c_WAIT_HI = 2'd2;
    localparam logic [1:0] c_HALT    = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN     = c_RUN,
        ST_WAIT_LO = c_WAIT_LO,
        ST_WAIT_HI = c_WAIT_HI,
        ST_HALT    = c_HALT
    } pcState_t;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
//  Module      : pc_ras
//  Description : Return-address stack. DEPTH must be a power of two (>= 2).
//                Overflowing pushes and underflowing pops are ignored here;
//                the caller decides how to flag them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pushData,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] top
);

    localparam int             c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_CNT_ONE = 1;
    localparam logic [c_PTR_W-1:0] c_IDX_ONE = 1;

    logic [ADDR_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W-1:0] w_wrIdx;
    logic [c_PTR_W-1:0] w_topIdx;

    // Count is one wider than the index, so its MSB alone means "full".
    assign w_wrIdx  = r_count[c_PTR_W-1:0];
    assign w_topIdx = w_wrIdx - c_IDX_ONE;
    assign full     = r_count[c_PTR_W];
    assign empty    = (r_count == '0);
    assign top      = r_mem[w_topIdx];

    // Occupancy counter; a push and pop together leave it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (push && !full && !(pop && !empty)) begin
            r_count <= r_count + c_CNT_ONE;
        end else if (pop && !empty && !(push && !full)) begin
            r_count <= r_count - c_CNT_ONE;
        end
    end

    // Entry storage needs no reset: only slots below the count are ever read
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wrIdx] <= pushData;
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
//  Module      : program_counter
//  Description : Fetch-address generator with branch/call/return handling,
//                a two-phase handshake with the downstream delay stage after
//                every redirect, and a halt state left only through reset.
//                Define PC_RAS_EN to build the return-address stack, call/ret
//                handling and the rasErr flag; otherwise call acts as a
//                plain branch, ret is ignored and rasErr is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcEn,
    input  logic              brValid,
    input  logic [ADDR_W-1:0] brTarget,
    input  logic              call,
    input  logic              ret,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              pcValid,
    output logic              delayEn,
    output logic              rasErr
);

    localparam logic [ADDR_W-1:0] c_ONE = 1;

    pcState_t          r_state;
    pcState_t          w_nextState;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pcNext;
    logic [ADDR_W-1:0] w_pcInc;
    logic [ADDR_W-1:0] w_popPc;
    logic              r_pcValid;
    logic              r_delayEn;
    logic              w_validNext;
    logic              w_delayNext;
    logic              w_advance;
    logic              w_doHalt;
    logic              w_doRet;
    logic              w_doCall;
    logic              w_doBr;
    logic              w_jump;

    assign w_pcInc = r_pc + c_ONE;

    // Requests are honoured only once the current pc has been presented as
    // valid; the first cycle after reset just raises pcValid.
    assign w_advance = (r_state == ST_RUN) && r_pcValid && pcEn;
    assign w_doHalt  = w_advance && halt;

`ifdef PC_RAS_EN
    logic              w_rasFull;
    logic              w_rasEmpty;
    logic [ADDR_W-1:0] w_rasTop;
    logic              r_rasErr;

    // ret wins over call, so a simultaneous pair never pushes
    assign w_doRet  = w_advance && !halt && ret;
    assign w_doCall = w_advance && !halt && !ret && call;
    assign w_doBr   = w_advance && !halt && !ret && !call && brValid;
    assign w_popPc  = w_rasEmpty ? RESET_PC : w_rasTop;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (w_doCall),
        .pop      (w_doRet),
        .pushData (w_pcInc),
        .full     (w_rasFull),
        .empty    (w_rasEmpty),
        .top      (w_rasTop)
    );

    // Sticky error on overflowing call or underflowing ret
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rasErr <= 1'b0;
        end else if ((w_doCall && w_rasFull) || (w_doRet && w_rasEmpty)) begin
            r_rasErr <= 1'b1;
        end
    end

    assign rasErr = r_rasErr;
`else
    logic w_unusedRet;

    assign w_unusedRet = ret;
    assign w_doRet     = 1'b0;
    assign w_doCall    = 1'b0;
    assign w_doBr      = w_advance && !halt && (brValid || call);
    assign w_popPc     = RESET_PC;
    assign rasErr      = 1'b0;
`endif

    assign w_jump = w_doRet || w_doCall || w_doBr;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: redirects wait for the delay stage to drop then re-raise pcEn
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_doHalt) begin
                    w_nextState = ST_HALT;
                end else if (w_jump) begin
                    w_nextState = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!pcEn) begin
                    w_nextState = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (pcEn) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_HALT: begin
                w_nextState = ST_HALT;
            end
            default: begin
                w_nextState = ST_RUN;
            end
        endcase
    end

    // Output decode: next pc, next pcValid and the redirect stall pulse
    always_comb begin
        w_pcNext    = r_pc;
        w_validNext = (w_nextState == ST_RUN);
        w_delayNext = w_jump;
        if (w_doRet) begin
            w_pcNext = w_popPc;
        end else if (w_doCall || w_doBr) begin
            w_pcNext = brTarget;
        end else if (w_advance && !w_doHalt) begin
            w_pcNext = w_pcInc;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_pcValid <= 1'b0;
            r_delayEn <= 1'b0;
        end else begin
            r_pc      <= w_pcNext;
            r_pcValid <= w_validNext;
            r_delayEn <= w_delayNext;
        end
    end

    assign pc      = r_pc;
    assign pcValid = r_pcValid;
    assign delayEn = r_delayEn;

endmodule

`default_nettype wire

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter ADDR_W, default 8, sets the PC width in bits.
REQ-002 Parameter RESET_PC, default 0, sets the PC value loaded at reset.
REQ-003 Parameter RAS_DEPTH, default 4, sets the return-address-stack entry count (power of 2).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pcEn  input  1  advance permission from the downstream delay stage; 0 = stalled.
REQ-007 brValid  input  1  taken-branch request.
REQ-008 brTarget  input  ADDR_W  branch or call target address.
REQ-009 call  input  1  call request (RAS push).
REQ-010 ret  input  1  return request (RAS pop).
REQ-011 halt  input  1  stop fetching.
REQ-012 pc  output  ADDR_W  current fetch address.
REQ-013 pcValid  output  1  pc is a valid fetch address this cycle.
REQ-014 delayEn  output  1  one-cycle, registered pulse that requests a stall from the delay stage.
REQ-015 rasErr  output  1  sticky RAS overflow/underflow flag.

Function
REQ-016 The FSM SHALL have states RUN, WAIT_LO, WAIT_HI and HALT.
REQ-017 pcValid SHALL be 1 only in RUN.
REQ-018 In RUN with pcEn=1, events SHALL take this priority: halt > ret > call > brValid > increment.
REQ-019 In RUN with pcEn=0, pc SHALL hold and all requests SHALL be ignored.
REQ-020 On increment, pc SHALL become pc+1 modulo 2^ADDR_W, so all-ones wraps to 0.
REQ-021 On brValid, pc SHALL load brTarget, delayEn SHALL pulse on the next cycle, and the FSM SHALL go to WAIT_LO.
REQ-022 On call, the block SHALL push pc+1 (wrapped), load brTarget, pulse delayEn and go to WAIT_LO.
REQ-023 On ret, the block SHALL pop the top entry into pc, pulse delayEn and go to WAIT_LO.
REQ-024 WAIT_LO SHALL go to WAIT_HI when pcEn is sampled 0; WAIT_HI SHALL go to RUN when pcEn is sampled 1; pc SHALL hold in both states.
REQ-025 halt SHALL move the FSM to HALT, hold pc and keep pcValid=0; only rst SHALL leave HALT.
REQ-026 A push when the RAS is full SHALL be discarded and SHALL set rasErr; the jump SHALL still be taken.
REQ-027 A pop when the RAS is empty SHALL load RESET_PC and SHALL set rasErr.
REQ-028 Simultaneous call and ret SHALL act as ret only, with no push.

Reset
REQ-029 rst SHALL immediately force pc=RESET_PC, pcValid=0, delayEn=0, rasErr=0, the RAS to empty and the FSM to RUN.
REQ-030 pcValid SHALL rise on the first clock edge after rst deasserts.
REQ-031 Reset asserted mid-WAIT or mid-HALT SHALL abandon that state with no residual delayEn.

Configuration
REQ-032 With macro PC_RAS_EN defined, the RAS, call/ret handling and rasErr SHALL be implemented.
REQ-033 Without PC_RAS_EN, call SHALL behave exactly as brValid, ret SHALL be ignored, and rasErr SHALL be tied to 0.

Structure
REQ-034 A shared package pc_pkg SHALL hold the FSM state enum and the RUN/WAIT_LO/WAIT_HI/HALT encodings.
REQ-035 The RAS SHALL be a sub-module named pc_ras (push, pop, full, empty, top).
REQ-036 The implementation SHALL stay within 120-400 lines of RTL.

Verification
REQ-037 Release rst with pcEn=1 held for 5 cycles -> pc sequence 0,1,2,3,4, pcValid=1 throughout.
REQ-038 pc=8'hFE, pcEn=1 -> pc goes 8'hFF then 8'h00.
REQ-039 brValid with brTarget=8'h40 at pc=5; pcEn goes low for 3 cycles, then high -> pc=8'h40, one delayEn pulse, pcValid=0 until pcEn returns, then pc=8'h41.
REQ-040 With PC_RAS_EN: call to 8'h20 at pc=8'h10, then ret -> pc returns to 8'h11; five nested calls with RAS_DEPTH=4 -> rasErr=1.
REQ-041 ret on an empty RAS -> pc=RESET_PC and rasErr=1; then rst -> rasErr=0.
REQ-042 halt asserted together with brValid -> HALT, pc held, no delayEn; rst asserted mid-WAIT_LO -> pc=RESET_PC asynchronously.
